// File: rtl/seven_segment_counter_if.sv
// Control/status bundle between firmware-facing logic and the seven-segment counter.
// Build option: SEVSEG_DOWN_COUNT_EN adds the up_down direction select.
interface seven_segment_counter_if;
    logic       enable;
    logic       clear;
    logic       load;
    logic [7:0] load_value;
`ifdef SEVSEG_DOWN_COUNT_EN
    logic       up_down;
`endif
    logic [7:0] count_bcd;
    logic       wrap;
    logic [6:0] segments;
    logic [1:0] digit_en;

`ifdef SEVSEG_DOWN_COUNT_EN
    modport master (
        output enable, clear, load, load_value, up_down,
        input  count_bcd, wrap, segments, digit_en
    );
    modport slave (
        input  enable, clear, load, load_value, up_down,
        output count_bcd, wrap, segments, digit_en
    );
`else
    modport master (
        output enable, clear, load, load_value,
        input  count_bcd, wrap, segments, digit_en
    );
    modport slave (
        input  enable, clear, load, load_value,
        output count_bcd, wrap, segments, digit_en
    );
`endif
endinterface

// File: rtl/seven_segment_counter.sv
// Two-digit BCD counter (00..99) with prescaled stepping and a time-multiplexed
// seven-segment display driver (one shared segment bus, two digit enables).
// Build option: SEVSEG_DOWN_COUNT_EN enables down-counting via bus.up_down.
module seven_segment_counter #(
    parameter int unsigned COUNT_PERIOD = 10_000_000,
    parameter int unsigned DIGIT_PERIOD = 1000
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    seven_segment_counter_if.slave  bus
);

    localparam int unsigned PW = (COUNT_PERIOD > 1) ? $clog2(COUNT_PERIOD) : 1;
    localparam int unsigned RW = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_PERIOD - 1);
    localparam logic [RW-1:0] REFR_LAST  = RW'(DIGIT_PERIOD - 1);

    // Count step helpers operate digit-wise so the value never leaves BCD.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = v[7:4];
        units = v[3:0];
        if (units == 4'd9) begin
            units = 4'd0;
            tens  = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
            units = units + 4'd1;
        end
        return {tens, units};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = v[7:4];
        units = v[3:0];
        if (units == 4'd0) begin
            units = 4'd9;
            tens  = (tens == 4'd0) ? 4'd9 : tens - 4'd1;
        end else begin
            units = units - 4'd1;
        end
        return {tens, units};
    endfunction

    // {g,f,e,d,c,b,a}, active high; non-decimal codes blank the digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    count_q, count_d;
    logic          wrap_q, wrap_d;
    logic [RW-1:0] refr_q, refr_d;
    logic [1:0]    digit_en_q, digit_en_d;
    logic [6:0]    seg_q, seg_d;

    logic          tick;
    logic          load_ok;
    logic          count_down;

`ifdef SEVSEG_DOWN_COUNT_EN
    assign count_down = bus.up_down;
`else
    assign count_down = 1'b0;
`endif

    // Out-of-range loads are dropped entirely so the tick still applies that cycle.
    assign tick    = bus.enable && (presc_q == PRESC_LAST);
    assign load_ok = bus.load && (bus.load_value[7:4] <= 4'd9) && (bus.load_value[3:0] <= 4'd9);

    // Next count/prescaler: clear beats load beats tick.
    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (bus.clear) begin
            presc_d = '0;
            count_d = 8'h00;
        end else if (load_ok) begin
            presc_d = '0;
            count_d = bus.load_value;
        end else if (bus.enable) begin
            if (tick) begin
                presc_d = '0;
                if (count_down) begin
                    count_d = bcd_dec(count_q);
                    wrap_d  = (count_q == 8'h00);
                end else begin
                    count_d = bcd_inc(count_q);
                    wrap_d  = (count_q == 8'h99);
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // Free-running digit refresh; segments decode from the next count and next
    // digit select so the bus and the enables always switch together.
    always_comb begin
        refr_d     = refr_q + 1'b1;
        digit_en_d = digit_en_q;
        if (refr_q == REFR_LAST) begin
            refr_d     = '0;
            digit_en_d = {digit_en_q[0], digit_en_q[1]};
        end
        seg_d = seg_decode(digit_en_d[1] ? count_d[7:4] : count_d[3:0]);
    end

    // State registers; reset drops any pending tick immediately.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            presc_q    <= '0;
            count_q    <= 8'h00;
            wrap_q     <= 1'b0;
            refr_q     <= '0;
            digit_en_q <= 2'b01;
            seg_q      <= 7'h3F;
        end else begin
            presc_q    <= presc_d;
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            refr_q     <= refr_d;
            digit_en_q <= digit_en_d;
            seg_q      <= seg_d;
        end
    end

    assign bus.count_bcd = count_q;
    assign bus.wrap      = wrap_q;
    assign bus.segments  = seg_q;
    assign bus.digit_en  = digit_en_q;

endmodule
